// File: rtl/counter_control_unit_if.sv
// Bundle of button, divider, limit-feedback and counter-control signals
// exchanged between the control front-end and its surroundings.
interface counter_control_unit_if #(
    parameter int DIV_WIDTH = 8
);
    logic                 DirButton;
    logic                 PauseButton;
    logic [DIV_WIDTH-1:0] Divide;
    logic                 LimitReachedFlag;
    logic                 ClkEnable;
    logic                 UpDownMode;
    logic                 Stop;
    logic                 DirChanged;

    modport master (
        output DirButton, PauseButton, Divide, LimitReachedFlag,
        input  ClkEnable, UpDownMode, Stop, DirChanged
    );

    modport slave (
        input  DirButton, PauseButton, Divide, LimitReachedFlag,
        output ClkEnable, UpDownMode, Stop, DirChanged
    );
endinterface

// File: rtl/counter_control_unit.sv
// Control front-end for the up/down counter: button debounce, count-rate
// prescaler and the RUN/HOLD/PAUSED direction/pause state machine.
module counter_control_unit #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DIV_WIDTH       = 8,
    parameter int HOLD_TICKS      = 3,
    parameter int AUTO_REVERSE    = 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    counter_control_unit_if.slave bus
);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

    typedef enum logic [1:0] {RUN, HOLD, PAUSED} state_t;

    // Index 0 is the direction button, index 1 the pause button.
    logic [1:0]      raw_btn;
    logic [1:0]      sync0;
    logic [1:0]      sync1;
    logic [1:0]      level;
    logic [1:0]      level_q;
    logic [1:0]      press;
    logic [DB_W-1:0] db_cnt [2];

    logic [DIV_WIDTH-1:0] pre_cnt;
    logic                 tick;

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              lim_q;
    logic              lim_rise;
    logic              up_mode;
    logic              stop;
    logic              dir_changed;
    logic              dir_press;
    logic              pause_press;

    assign raw_btn     = {bus.PauseButton, bus.DirButton};
    assign dir_press   = press[0];
    assign pause_press = press[1];
    assign lim_rise    = bus.LimitReachedFlag & ~lim_q;

    // Press pulses are registered after the level flip, so a held button
    // acts DEBOUNCE_CYCLES+3 edges after it is first sampled.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync0   <= '0;
            sync1   <= '0;
            level   <= '0;
            level_q <= '0;
            press   <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync0   <= raw_btn;
            sync1   <= sync0;
            level_q <= level;
            press   <= level & ~level_q;
            for (int i = 0; i < 2; i++) begin
                if (sync1[i] != level[i]) begin
                    if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        level[i]  <= ~level[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // The >= compare lets a lowered Divide wrap on the very next edge.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pre_cnt <= '0;
            tick    <= 1'b0;
        end else if (pre_cnt >= bus.Divide) begin
            pre_cnt <= '0;
            tick    <= 1'b1;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
            tick    <= 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state       <= RUN;
            up_mode     <= 1'b1;
            stop        <= 1'b0;
            dir_changed <= 1'b0;
            hold_cnt    <= '0;
            lim_q       <= 1'b0;
        end else begin
            lim_q       <= bus.LimitReachedFlag;
            dir_changed <= 1'b0;
            if (dir_press) begin
                up_mode     <= ~up_mode;
                dir_changed <= 1'b1;
            end
            case (state)
                RUN: begin
                    if (pause_press) begin
                        state <= PAUSED;
                        stop  <= 1'b1;
                    end else if (AUTO_REVERSE != 0 && lim_rise) begin
                        state    <= HOLD;
                        stop     <= 1'b1;
                        hold_cnt <= '0;
                    end
                end
                HOLD: begin
                    // A manual direction press replaces the pending auto-reverse.
                    if (pause_press) begin
                        state <= PAUSED;
                    end else if (dir_press) begin
                        state <= RUN;
                        stop  <= 1'b0;
                    end else if (tick) begin
                        if (hold_cnt == HOLD_W'(HOLD_TICKS - 1)) begin
                            up_mode     <= ~up_mode;
                            dir_changed <= 1'b1;
                            state       <= RUN;
                            stop        <= 1'b0;
                            hold_cnt    <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                PAUSED: begin
                    if (pause_press) begin
                        state <= RUN;
                        stop  <= 1'b0;
                    end
                end
                default: begin
                    state <= RUN;
                    stop  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ClkEnable  = tick;
    assign bus.UpDownMode = up_mode;
    assign bus.Stop       = stop;
    assign bus.DirChanged = dir_changed;
endmodule

// File: tb/tb_counter_control_unit.sv
// Scoreboard bench: stimulus queues expected output events and tick times,
// a negedge monitor pops and compares them as the outputs change.
module tb_counter_control_unit;
    logic Clk = 1'b0;
    logic Reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        int   cyc;
        logic up;
        logic stop;
        logic dch;
    } ev_t;

    ev_t  exp_q[$];
    int   tick_q[$];
    bit   mon_en = 1'b0;
    bit   tick_en = 1'b0;
    logic [2:0] prev_out = 3'b100;
    int   ev_idx = 0;
    int   rel_cyc;

    counter_control_unit_if #(.DIV_WIDTH(8)) bus();

    counter_control_unit #(
        .DEBOUNCE_CYCLES(4),
        .DIV_WIDTH(8),
        .HOLD_TICKS(3),
        .AUTO_REVERSE(1)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .bus(bus)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // Monitor: any change of {UpDownMode, Stop, DirChanged} must match the next queued event.
    always @(negedge Clk) begin
        logic [2:0] cur;
        ev_t e;
        int  t;
        cur = {bus.UpDownMode, bus.Stop, bus.DirChanged};
        if (mon_en && cur !== prev_out) begin
            total++;
            ev_idx++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL event%0d: got cyc=%0d up/stop/dch=%b, want no change", ev_idx, cyc, cur);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || cur !== {e.up, e.stop, e.dch}) begin
                    bad++;
                    $display("[TB] FAIL event%0d: got cyc=%0d up/stop/dch=%b, want cyc=%0d up/stop/dch=%b",
                             ev_idx, cyc, cur, e.cyc, {e.up, e.stop, e.dch});
                end
            end
        end
        prev_out = cur;
        if (tick_en && bus.ClkEnable === 1'b1) begin
            total++;
            if (tick_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL tick: got tick at cyc=%0d, want none", cyc);
            end else begin
                t = tick_q.pop_front();
                if (t != cyc) begin
                    bad++;
                    $display("[TB] FAIL tick: got tick at cyc=%0d, want cyc=%0d", cyc, t);
                end
            end
        end
    end

    task automatic check_output(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    task automatic push_ev(input int c, input logic up, input logic stop, input logic dch);
        ev_t e;
        e.cyc  = c;
        e.up   = up;
        e.stop = stop;
        e.dch  = dch;
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge Clk);
    endtask

    task automatic push_ticks(input int first, input int period, input int n);
        for (int i = 0; i < n; i++) tick_q.push_back(first + i * period);
    endtask

    // Hold the chosen button for 8 cycles from the current negedge, then let it settle.
    task automatic press_button(input bit pause);
        if (pause) bus.PauseButton = 1'b1;
        else       bus.DirButton   = 1'b1;
        repeat (8) @(negedge Clk);
        bus.PauseButton = 1'b0;
        bus.DirButton   = 1'b0;
        repeat (12) @(negedge Clk);
    endtask

    task automatic apply_stimulus;
        int  base;
        int  lim;
        int  nxt;
        int  tmark;
        bit  got;

        bus.DirButton        = 1'b0;
        bus.PauseButton      = 1'b0;
        bus.LimitReachedFlag = 1'b0;
        bus.Divide           = 8'd4;
        Reset = 1'b1;
        #1 Reset = 1'b0;
        repeat (3) @(negedge Clk);
        check_output("reset_up",   int'(bus.UpDownMode), 1);
        check_output("reset_stop", int'(bus.Stop), 0);
        check_output("reset_ce",   int'(bus.ClkEnable), 0);
        check_output("reset_dch",  int'(bus.DirChanged), 0);
        prev_out = 3'b100;
        mon_en   = 1'b1;

        // Divide=4: ticks every 5th cycle counted from reset release.
        Reset   = 1'b1;
        rel_cyc = cyc;
        push_ticks(rel_cyc + 5, 5, 4);
        tick_en = 1'b1;
        wait_until(rel_cyc + 22);
        tick_en = 1'b0;
        check_output("ticks_after_reset_left", tick_q.size(), 0);

        // Two-cycle direction glitch must be filtered.
        bus.DirButton = 1'b1;
        repeat (2) @(negedge Clk);
        bus.DirButton = 1'b0;
        repeat (10) @(negedge Clk);

        base = cyc;
        push_ev(base + 8, 1'b0, 1'b0, 1'b1);
        push_ev(base + 9, 1'b0, 1'b0, 1'b0);
        press_button(1'b0);

        base = cyc;
        push_ev(base + 8, 1'b0, 1'b1, 1'b0);
        press_button(1'b1);
        nxt = rel_cyc + 5 * ((cyc - rel_cyc) / 5 + 1);
        push_ticks(nxt, 5, 3);
        tick_en = 1'b1;
        wait_until(nxt + 12);
        tick_en = 1'b0;
        check_output("ticks_paused_left", tick_q.size(), 0);
        base = cyc;
        push_ev(base + 8, 1'b0, 1'b0, 1'b0);
        press_button(1'b1);

        // Auto-reverse with Divide=0: three HOLD cycles, then one reversal only.
        bus.Divide = 8'd0;
        repeat (3) @(negedge Clk);
        bus.LimitReachedFlag = 1'b1;
        lim = cyc;
        push_ev(lim + 1, 1'b0, 1'b1, 1'b0);
        push_ev(lim + 4, 1'b1, 1'b0, 1'b1);
        push_ev(lim + 5, 1'b1, 1'b0, 1'b0);
        repeat (20) @(negedge Clk);
        bus.LimitReachedFlag = 1'b0;
        repeat (3) @(negedge Clk);

        // Direction press during HOLD cancels the auto-reverse.
        bus.Divide = 8'd50;
        bus.LimitReachedFlag = 1'b1;
        lim = cyc;
        push_ev(lim + 1, 1'b1, 1'b1, 1'b0);
        wait_until(lim + 3);
        base = cyc;
        push_ev(base + 8, 1'b0, 1'b0, 1'b1);
        push_ev(base + 9, 1'b0, 1'b0, 1'b0);
        press_button(1'b0);
        repeat (200) @(negedge Clk);
        bus.LimitReachedFlag = 1'b0;
        repeat (3) @(negedge Clk);

        // Pause press during HOLD: Stop stays high, no reversal ever follows.
        bus.LimitReachedFlag = 1'b1;
        lim = cyc;
        push_ev(lim + 1, 1'b0, 1'b1, 1'b0);
        wait_until(lim + 3);
        press_button(1'b1);
        repeat (250) @(negedge Clk);
        bus.LimitReachedFlag = 1'b0;
        repeat (2) @(negedge Clk);
        base = cyc;
        push_ev(base + 8, 1'b0, 1'b0, 1'b0);
        press_button(1'b1);

        // Lowering Divide from 200 to 10 with the prescaler at 150.
        bus.Divide = 8'd200;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge Clk);
            if (bus.ClkEnable === 1'b1) got = 1'b1;
        end
        check_output("divide200_tick_seen", int'(got), 1);
        tmark = cyc;
        wait_until(tmark + 150);
        bus.Divide = 8'd10;
        push_ticks(tmark + 151, 11, 4);
        tick_en = 1'b1;
        wait_until(tmark + 186);
        tick_en = 1'b0;
        check_output("ticks_divide10_left", tick_q.size(), 0);

        // Reset dropped mid-HOLD returns outputs at once.
        bus.Divide = 8'd0;
        repeat (3) @(negedge Clk);
        bus.LimitReachedFlag = 1'b1;
        lim = cyc;
        push_ev(lim + 1, 1'b0, 1'b1, 1'b0);
        wait_until(lim + 2);
        push_ev(lim + 3, 1'b1, 1'b0, 1'b0);
        #2 Reset = 1'b0;
        #1;
        check_output("midhold_reset_up",   int'(bus.UpDownMode), 1);
        check_output("midhold_reset_stop", int'(bus.Stop), 0);
        check_output("midhold_reset_ce",   int'(bus.ClkEnable), 0);
        check_output("midhold_reset_dch",  int'(bus.DirChanged), 0);
        bus.LimitReachedFlag = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        repeat (12) @(negedge Clk);
        check_output("events_left", exp_q.size(), 0);
    endtask

    initial begin
        $display("[TB] counter_control_unit scoreboard bench");
        apply_stimulus();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
